pmem_arbiter: RTL

//  Sequences the single shared physical-memory port between the I-cache and D-cache

---
 rtl/pmem_arbiter_if.sv | 47 ++++
 rtl/pmem_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/pmem_arbiter_if.sv
// Signal bundle around the shared physical-memory port: I-cache side, D-cache side and memory side.
// Handshake: every request (i_pmem_read, d_pmem_read, d_pmem_write, pmem_read, pmem_write) is a level
// held for the whole transaction; the matching *_resp is a one-cycle pulse that completes it and
// qualifies *_rdata in that same cycle. The requester may drop its level in the cycle after *_resp.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // master: the arbiter, which owns the memory strobes and the completion pulses
  modport master (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // slave: the caches and the memory around the arbiter
  modport slave (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbiter for the single physical-memory port shared by I-cache fills and D-cache fills/writebacks.
// D-side has priority; after STARVE_MAX consecutive D grants with I waiting, the next grant goes to I.
module pmem_arbiter #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  pmem_arbiter_if.master   bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             starve_hit;
  logic             serve_i;
  logic             serve_d;

  assign d_req      = bus.d_pmem_read | bus.d_pmem_write;
  assign starve_hit = bus.i_pmem_read && (starve_cnt == CNT_W'(STARVE_MAX));

  // The response path is combinational from pmem_resp and only open to the granted side.
  assign serve_i = !rst && (state == SERVE_I);
  assign serve_d = !rst && (state == SERVE_D);

  assign bus.i_pmem_resp  = serve_i && bus.pmem_resp;
  assign bus.d_pmem_resp  = serve_d && bus.pmem_resp;
  assign bus.i_pmem_rdata = serve_i ? bus.pmem_rdata : '0;
  assign bus.d_pmem_rdata = serve_d ? bus.pmem_rdata : '0;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !starve_hit) begin
            state            <= SERVE_D;
            bus.pmem_address <= bus.d_pmem_address;
            bus.pmem_wdata   <= bus.d_pmem_wdata;
            // A request with both read and write set is treated as a writeback.
            bus.pmem_write   <= bus.d_pmem_write;
            bus.pmem_read    <= !bus.d_pmem_write;
            if (!bus.i_pmem_read) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (bus.i_pmem_read) begin
            state            <= SERVE_I;
            bus.pmem_address <= bus.i_pmem_address;
            bus.pmem_read    <= 1'b1;
            bus.pmem_write   <= 1'b0;
            starve_cnt       <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            state          <= DONE;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
          end
        end
        DONE: begin
          // Dead cycle lets the requester drop its level before the next arbitration.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.pmem_read && bus.pmem_write));
      assert (!(bus.i_pmem_resp && bus.d_pmem_resp));
    end
  end

endmodule
